// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and I/O offsets for the memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAM_RD = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RAM      = 2'd0,
        IO       = 2'd1,
        UNMAPPED = 2'd2
    } region_e;

    localparam logic [1:0] c_io_led    = 2'd0;
    localparam logic [1:0] c_io_sw     = 2'd1;
    localparam logic [1:0] c_io_cnt_lo = 2'd2;
    localparam logic [1:0] c_io_cnt_hi = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_ram.sv
// ============================================================================
// Module      : sync_ram
// Description : Single-port RAM, synchronous write, registered 1-cycle read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ram #(
    parameter int DATA_W    = 16,
    parameter int RAM_DEPTH = 4096,
    parameter int RAM_AW    = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [RAM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Core memory-port controller: RAM, 4-word I/O window, holes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int               ADDR_W    = 24,
    parameter int               DATA_W    = 16,
    parameter int               RAM_DEPTH = 4096,
    parameter logic [ADDR_W-1:0] IO_BASE  = 24'hFF0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_err,
    output logic [DATA_W-1:0] led_out,
    input  logic [DATA_W-1:0] sw_in
);

    localparam int c_ram_aw = $clog2(RAM_DEPTH);

    state_e            r_state;
    state_e            w_next_state;
    region_e           w_region;
    logic [ADDR_W-1:0] w_io_off;
    logic [DATA_W-1:0] w_io_rdata;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_accept;
    logic              w_ram_we;
    logic [31:0]       r_cnt;
    logic [DATA_W-1:0] r_cnt_shadow;
    logic [DATA_W-1:0] r_sw_meta;
    logic [DATA_W-1:0] r_sw_sync;
    logic [DATA_W-1:0] r_led;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    assign w_accept = (r_state == IDLE) && core_req;
    assign w_ram_we = w_accept && core_we && (w_region == RAM);

    always_comb begin
        w_io_off = core_addr - IO_BASE;
        if (core_addr < ADDR_W'(RAM_DEPTH)) begin
            w_region = RAM;
        end else if (w_io_off < ADDR_W'(4)) begin
            w_region = IO;
        end else begin
            w_region = UNMAPPED;
        end
    end

    always_comb begin
        w_io_rdata = '0;
        case (w_io_off[1:0])
            c_io_led:    w_io_rdata = r_led;
            c_io_sw:     w_io_rdata = r_sw_sync;
            c_io_cnt_lo: w_io_rdata = DATA_W'(r_cnt[15:0]);
            c_io_cnt_hi: w_io_rdata = r_cnt_shadow;
            default:     w_io_rdata = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (core_req) begin
                    w_next_state = ((w_region == RAM) && !core_we) ? RAM_RD : RESP;
                end
            end
            RAM_RD:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    sync_ram #(
        .DATA_W    (DATA_W),
        .RAM_DEPTH (RAM_DEPTH),
        .RAM_AW    (c_ram_aw)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (core_addr[c_ram_aw-1:0]),
        .wdata (core_wdata),
        .rdata (w_ram_rdata)
    );

    // Non-RAM results are resolved at acceptance; RAM reads land one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cnt_shadow <= '0;
            r_sw_meta    <= '0;
            r_sw_sync    <= '0;
            r_led        <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= r_cnt + 32'd1;
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
            r_err     <= 1'b0;
            if (r_state == RAM_RD) begin
                r_rdata <= w_ram_rdata;
            end
            if (w_accept) begin
                case (w_region)
                    IO: begin
                        if (core_we) begin
                            if (w_io_off[1:0] == c_io_led) begin
                                r_led <= core_wdata;
                            end
                        end else begin
                            r_rdata <= w_io_rdata;
                            if (w_io_off[1:0] == c_io_cnt_lo) begin
                                r_cnt_shadow <= DATA_W'(r_cnt[31:16]);
                            end
                        end
                    end
                    UNMAPPED: begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign core_ack   = (r_state == RESP);
    assign core_err   = r_err;
    assign core_rdata = r_rdata;
    assign led_out    = r_led;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [23:0] core_addr;
    logic [15:0] core_wdata;
    logic [15:0] core_rdata;
    logic        core_ack;
    logic        core_err;
    logic [15:0] led_out;
    logic [15:0] sw_in;

    int total;
    int bad;

    // Reference cycle counter: counts rising edges since reset release.
    logic [31:0] ref_cyc;

    mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ack   (core_ack),
        .core_err   (core_err),
        .led_out    (led_out),
        .sw_in      (sw_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_cyc <= '0;
        else        ref_cyc <= ref_cyc + 32'd1;
    end

    // One access; lat = cycles from acceptance to ack (0 on timeout).
    task automatic access(input logic we, input logic [23:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output logic err, output int lat,
                          output logic [15:0] led1, output logic [31:0] cyc_at_accept);
        @(negedge clk);
        core_req      = 1'b1;
        core_we       = we;
        core_addr     = addr;
        core_wdata    = wdata;
        cyc_at_accept = ref_cyc;
        @(posedge clk);
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        led1  = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) led1 = led_out;
            if (core_ack) begin
                lat   = i;
                rdata = core_rdata;
                err   = core_err;
                break;
            end
        end
        core_req = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (core_ack !== 1'b0)     begin bad++; $display("FAIL reset_ack got=%b want=0", core_ack); end
        total++; if (core_err !== 1'b0)     begin bad++; $display("FAIL reset_err got=%b want=0", core_err); end
        total++; if (core_rdata !== 16'h0)  begin bad++; $display("FAIL reset_rdata got=%h want=0000", core_rdata); end
        total++; if (led_out !== 16'h0)     begin bad++; $display("FAIL reset_led got=%h want=0000", led_out); end
    endtask

    task automatic test_ram();
        logic [15:0] rd, l1; logic e; int lat; logic [31:0] c;
        access(1'b1, 24'h000010, 16'hBEEF, rd, e, lat, l1, c);
        total++; if (lat !== 1)   begin bad++; $display("FAIL ram_wr_lat got=%0d want=1", lat); end
        total++; if (e !== 1'b0)  begin bad++; $display("FAIL ram_wr_err got=%b want=0", e); end
        access(1'b0, 24'h000010, 16'h0, rd, e, lat, l1, c);
        total++; if (lat !== 2)          begin bad++; $display("FAIL ram_rd_lat got=%0d want=2", lat); end
        total++; if (rd !== 16'hBEEF)    begin bad++; $display("FAIL ram_rd_data got=%h want=beef", rd); end
        total++; if (e !== 1'b0)         begin bad++; $display("FAIL ram_rd_err got=%b want=0", e); end
    endtask

    task automatic test_led();
        logic [15:0] rd, l1; logic e; int lat; logic [31:0] c;
        access(1'b1, 24'hFF0000, 16'h00A5, rd, e, lat, l1, c);
        total++; if (lat !== 1)       begin bad++; $display("FAIL led_wr_lat got=%0d want=1", lat); end
        total++; if (l1 !== 16'h00A5) begin bad++; $display("FAIL led_out got=%h want=00a5", l1); end
        access(1'b0, 24'hFF0000, 16'h0, rd, e, lat, l1, c);
        total++; if (lat !== 1)       begin bad++; $display("FAIL led_rd_lat got=%0d want=1", lat); end
        total++; if (rd !== 16'h00A5) begin bad++; $display("FAIL led_rd_data got=%h want=00a5", rd); end
    endtask

    task automatic test_sw();
        logic [15:0] rd, l1; logic e; int lat; logic [31:0] c;
        @(negedge clk);
        sw_in = 16'h1234;
        repeat (3) @(negedge clk);
        access(1'b0, 24'hFF0001, 16'h0, rd, e, lat, l1, c);
        total++; if (lat !== 1)       begin bad++; $display("FAIL sw_rd_lat got=%0d want=1", lat); end
        total++; if (rd !== 16'h1234) begin bad++; $display("FAIL sw_rd_data got=%h want=1234", rd); end
        access(1'b1, 24'hFF0001, 16'hFFFF, rd, e, lat, l1, c);
        total++; if (lat !== 1)       begin bad++; $display("FAIL sw_wr_ack got=%0d want=1", lat); end
        total++; if (e !== 1'b0)      begin bad++; $display("FAIL sw_wr_err got=%b want=0", e); end
        access(1'b0, 24'hFF0001, 16'h0, rd, e, lat, l1, c);
        total++; if (rd !== 16'h1234) begin bad++; $display("FAIL sw_rd_after_wr got=%h want=1234", rd); end
    endtask

    task automatic test_counter();
        logic [15:0] rd, l1; logic e; int lat; logic [31:0] c_lo, c_hi; int guard;
        guard = 0;
        while (ref_cyc != 32'h0000FFFD && guard < 80000) begin
            @(negedge clk);
            guard++;
        end
        total++; if (ref_cyc !== 32'h0000FFFD) begin bad++; $display("FAIL cnt_wait got=%h want=0000fffd", ref_cyc); end
        // Low read lands at cnt=FFFE; high read happens after the 16-bit carry.
        access(1'b0, 24'hFF0002, 16'h0, rd, e, lat, l1, c_lo);
        total++; if (rd !== 16'hFFFE) begin bad++; $display("FAIL cnt_lo got=%h want=fffe", rd); end
        total++; if (lat !== 1)       begin bad++; $display("FAIL cnt_lo_lat got=%0d want=1", lat); end
        access(1'b0, 24'hFF0003, 16'h0, rd, e, lat, l1, c_hi);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL cnt_hi_shadow got=%h want=0000", rd); end
        access(1'b0, 24'hFF0002, 16'h0, rd, e, lat, l1, c_lo);
        total++; if (rd !== c_lo[15:0]) begin bad++; $display("FAIL cnt_lo2 got=%h want=%h", rd, c_lo[15:0]); end
        access(1'b0, 24'hFF0003, 16'h0, rd, e, lat, l1, c_hi);
        total++; if (rd !== 16'h0001) begin bad++; $display("FAIL cnt_hi2 got=%h want=0001", rd); end
    endtask

    task automatic test_unmapped();
        logic [15:0] rd, l1; logic e; int lat; logic [31:0] c;
        access(1'b1, 24'h000000, 16'h1111, rd, e, lat, l1, c);
        access(1'b0, 24'h800000, 16'h0, rd, e, lat, l1, c);
        total++; if (lat !== 1)       begin bad++; $display("FAIL unm_rd_lat got=%0d want=1", lat); end
        total++; if (e !== 1'b1)      begin bad++; $display("FAIL unm_rd_err got=%b want=1", e); end
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL unm_rd_data got=%h want=0000", rd); end
        access(1'b1, 24'h800000, 16'h2222, rd, e, lat, l1, c);
        total++; if (lat !== 1)       begin bad++; $display("FAIL unm_wr_lat got=%0d want=1", lat); end
        total++; if (e !== 1'b1)      begin bad++; $display("FAIL unm_wr_err got=%b want=1", e); end
        @(negedge clk);
        total++; if (core_err !== 1'b0) begin bad++; $display("FAIL err_idle got=%b want=0", core_err); end
        access(1'b0, 24'h000000, 16'h0, rd, e, lat, l1, c);
        total++; if (rd !== 16'h1111) begin bad++; $display("FAIL unm_ram_intact got=%h want=1111", rd); end
        total++; if (e !== 1'b0)      begin bad++; $display("FAIL ram_rd_err2 got=%b want=0", e); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd, l1; logic e; int lat; logic [31:0] c; int acks;
        access(1'b1, 24'hFF0000, 16'h5A5A, rd, e, lat, l1, c);
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 24'h000010;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (core_ack !== 1'b0)    begin bad++; $display("FAIL rst_mid_ack got=%b want=0", core_ack); end
        total++; if (dut.r_state !== IDLE) begin bad++; $display("FAIL rst_mid_state got=%0d want=0", dut.r_state); end
        total++; if (led_out !== 16'h0)    begin bad++; $display("FAIL rst_mid_led got=%h want=0000", led_out); end
        core_req = 1'b0;
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (core_ack) acks++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (core_ack) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rst_mid_noack got=%0d want=0", acks); end
        access(1'b0, 24'h000010, 16'h0, rd, e, lat, l1, c);
        total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rst_ram_kept got=%h want=beef", rd); end
        total++; if (lat !== 2)       begin bad++; $display("FAIL rst_ram_lat got=%0d want=2", lat); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        sw_in      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_ram();
        test_led();
        test_sw();
        test_unmapped();
        test_counter();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Word-addressed memory controller that sits directly downstream of the CPU core. It services the core's memory port: instruction fetch, LOAD and STORE. It decodes each 24-bit address into a block-RAM region, a small memory-mapped I/O region, or an unmapped hole. Every access completes with a one-cycle acknowledge pulse and, for reads, valid data.

## Interface
Parameters:
- ADDR_W, 24, address width (word addresses)
- DATA_W, 16, data word width
- RAM_DEPTH, 4096, RAM words; RAM occupies addresses 0 .. RAM_DEPTH-1
- IO_BASE, 24'hFF0000, base word address of the 4-word I/O window

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- core_req  in  1  access request; held until core_ack
- core_we  in  1  1 = write, 0 = read; qualified by core_req
- core_addr  in  ADDR_W  word address
- core_wdata  in  DATA_W  write data
- core_rdata  out  DATA_W  read data; valid only while core_ack = 1
- core_ack  out  1  single-cycle completion pulse
- core_err  out  1  unmapped access flag; valid with core_ack
- led_out  out  DATA_W  LED register
- sw_in  in  DATA_W  asynchronous switch inputs

## Operation
- FSM states are IDLE, RAM_RD and RESP.
- Acceptance: the request is accepted on a rising edge where the state is IDLE and core_req = 1. Address, we and wdata are latched at that edge.
- Transitions:
  - RAM read: IDLE -> RAM_RD -> RESP.
  - All other accesses: IDLE -> RESP.
  - RESP -> IDLE always.
- core_ack = 1 exactly while the state is RESP.
- core_req is ignored outside IDLE. A request still asserted in the IDLE cycle after RESP is accepted as a new access, so the core must drop core_req on the edge that ends ack.
- RAM write: the RAM is written at the acceptance edge.
- RAM read: the RAM is addressed at the acceptance edge. Registered RAM output is captured into core_rdata on entry to RESP.
- I/O window (offsets from IO_BASE):
  - +0 LED: read/write; led_out updates at the acceptance edge.
  - +1 switches: read-only; returns the 2-flop-synchronised sw_in sampled at the acceptance edge; writes are dropped but acknowledged.
  - +2 counter low: read returns cnt[15:0] and captures cnt[31:16] into a shadow register at the same edge.
  - +3 counter high: read returns the shadow; writes to +2 and +3 are dropped.
- cnt is a 32-bit free-running cycle counter. It increments every cycle and wraps from 2^32-1 to 0.
- Unmapped addresses (not RAM, not I/O) return core_err = 1 with core_rdata = 0. Writes to them are dropped. Latency matches a write (1 cycle).
- core_err = 0 for all mapped accesses.
- Outputs when not acknowledging: core_rdata holds its last value and core_err = 0.
- Reset values: state IDLE, core_ack 0, core_err 0, core_rdata 0, led_out 0, cnt 0, shadow 0, synchroniser flops 0. RAM contents are not reset.
- Reset mid-access aborts the access. No ack is issued. A RAM write already committed at acceptance stays committed.

## Timing
- Accept at edge N; then:
  - write, I/O read, or unmapped access: ack high in cycle N+1;
  - RAM read: ack high in cycle N+2.
- Minimum spacing between accesses is 2 cycles (non-RAM-read) or 3 cycles (RAM read), counted acceptance to acceptance.
- Counter value returned is cnt as sampled at the acceptance edge.
- There is a 2-cycle synchroniser delay from sw_in to a readable value.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, RAM_RD, RESP);
  - the I/O offset constants (LED, SW, CNT_LO, CNT_HI);
  - the region-decode result enum (RAM, IO, UNMAPPED).
- One sub-module, sync_ram: single-port, DATA_W x RAM_DEPTH, synchronous write, registered read, 1-cycle read latency; index is address bits [log2(RAM_DEPTH)-1:0].
- Decode, I/O registers, counter, synchroniser and FSM live in mem_ctrl.

## Test plan
- After reset: write 16'hBEEF to address 24'h000010; ack at N+1, err = 0. Read 24'h000010; ack at N+2, rdata = 16'hBEEF.
- Write 16'h00A5 to 24'hFF0000; led_out = 16'h00A5 the cycle after acceptance. Read it back; rdata = 16'h00A5 with ack at N+1.
- Drive sw_in = 16'h1234, wait 3 cycles, read 24'hFF0001; rdata = 16'h1234. Write 16'hFFFF to 24'hFF0001; ack = 1, next read still returns 16'h1234.
- Force cnt near 32'h0000FFFE; read +2, then +3. The high word equals the value captured with the low read and is not re-sampled, including across the 16-bit carry.
- Read 24'h800000 (unmapped); ack at N+1, err = 1, rdata = 0. Write to it; err = 1, RAM unchanged.
- Assert rst_n low in the RAM_RD cycle of a read; no ack, state IDLE, led_out = 0. After release, a new read of a previously written address returns the stored data.
